// File: rtl/iterative_sqrt_responder.sv
// iterative_sqrt_responder: valid/ready square-root engine.
// Computes floor(sqrt(n)) with a restoring digit-by-digit loop, one root bit per clock.
// Optional macro ISQRT_REMAINDER_EN adds output chan_rem = n - root^2.
module iterative_sqrt_responder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] chan_n,
  input  logic             chan_n_vld,
  output logic             chan_n_rdy,
  output logic [WIDTH-1:0] chan_result,
  output logic             chan_result_vld,
  input  logic             chan_result_rdy
`ifdef ISQRT_REMAINDER_EN
  ,
  output logic [WIDTH/2:0] chan_rem
`endif
);

  localparam int unsigned N    = WIDTH / 2;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  // Odd or sub-2 widths have no meaningful root/remainder split.
  if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_width_check
    $error("iterative_sqrt_responder: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e r_state;
  state_e w_state_d;

  logic [WIDTH-1:0] r_x;       // operand, consumed two bits per iteration from the top
  logic [N-1:0]     r_root;    // partial root
  logic [N+1:0]     r_rem;     // partial remainder
  logic [CntW-1:0]  r_count;   // iterations left after the current one
  logic [WIDTH-1:0] r_result;

  logic             w_load_op;
  logic             w_iter;
  logic             w_finish;
  logic             w_n_rdy;
  logic             w_res_vld;

  logic [N+3:0]     w_rem_sh;
  logic [N+3:0]     w_trial;
  logic             w_ge;
  logic [N+1:0]     w_rem_nxt;
  logic [N-1:0]     w_root_nxt;

  // One restoring iteration: bring down the next bit pair and try subtracting 4*root+1.
  always_comb begin
    w_rem_sh   = {r_rem, r_x[WIDTH-1 -: 2]};
    w_trial    = {2'b00, r_root, 2'b01};
    w_ge       = (w_rem_sh >= w_trial);
    w_rem_nxt  = (N + 2)'(w_ge ? (w_rem_sh - w_trial) : w_rem_sh);
    w_root_nxt = N'({r_root, w_ge});
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state and handshake decode; outputs depend on registered state only.
  always_comb begin
    w_state_d = r_state;
    w_load_op = 1'b0;
    w_iter    = 1'b0;
    w_finish  = 1'b0;
    w_n_rdy   = 1'b0;
    w_res_vld = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_n_rdy = 1'b1;
        if (chan_n_vld) begin
          w_load_op = 1'b1;
          w_state_d = StCalc;
        end
      end
      StCalc: begin
        w_iter = 1'b1;
        if (r_count == '0) begin
          w_finish  = 1'b1;
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_res_vld = 1'b1;
        if (chan_result_rdy) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Iteration datapath: load on accept, step once per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_root  <= '0;
      r_rem   <= '0;
      r_count <= '0;
    end else if (w_load_op) begin
      r_x     <= chan_n;
      r_root  <= '0;
      r_rem   <= '0;
      r_count <= CntW'(N - 1);
    end else if (w_iter) begin
      r_x    <= r_x << 2;
      r_root <= w_root_nxt;
      r_rem  <= w_rem_nxt;
      if (!w_finish) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  // Result register: loaded on the last iteration, held until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else if (w_finish) begin
      r_result <= {{(WIDTH - N){1'b0}}, w_root_nxt};
    end
  end

`ifdef ISQRT_REMAINDER_EN
  logic [N:0] r_rem_out;

  // Final remainder never exceeds 2*root, so N+1 bits hold it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem_out <= '0;
    end else if (w_finish) begin
      r_rem_out <= w_rem_nxt[N:0];
    end
  end

  assign chan_rem = r_rem_out;
`endif

  assign chan_n_rdy      = w_n_rdy;
  assign chan_result_vld = w_res_vld;
  assign chan_result     = r_result;

endmodule

// File: tb/tb_iterative_sqrt_responder.sv
// Self-checking bench for iterative_sqrt_responder (WIDTH=8 and WIDTH=16 instances).
// Optional macro ISQRT_REMAINDER_EN enables the remainder checks.
module tb_iterative_sqrt_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  n8, res8;
  logic        nvld8, nrdy8, rvld8, rrdy8;
  logic [15:0] n16, res16;
  logic        nvld16, nrdy16, rvld16, rrdy16;
`ifdef ISQRT_REMAINDER_EN
  logic [4:0]  rem8;
  logic [8:0]  rem16;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  iterative_sqrt_responder #(.WIDTH(8)) dut8 (
    .clk             (clk),
    .rst_n           (rst_n),
    .chan_n          (n8),
    .chan_n_vld      (nvld8),
    .chan_n_rdy      (nrdy8),
    .chan_result     (res8),
    .chan_result_vld (rvld8),
    .chan_result_rdy (rrdy8)
`ifdef ISQRT_REMAINDER_EN
    ,
    .chan_rem        (rem8)
`endif
  );

  iterative_sqrt_responder #(.WIDTH(16)) dut16 (
    .clk             (clk),
    .rst_n           (rst_n),
    .chan_n          (n16),
    .chan_n_vld      (nvld16),
    .chan_n_rdy      (nrdy16),
    .chan_result     (res16),
    .chan_result_vld (rvld16),
    .chan_result_rdy (rrdy16)
`ifdef ISQRT_REMAINDER_EN
    ,
    .chan_rem        (rem16)
`endif
  );

  // Reference: largest r with r*r <= v.
  function automatic int unsigned model_sqrt(input int unsigned v);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Runs one WIDTH=8 operation with no backpressure; cyc counts from the accept cycle (0).
  task automatic drive8(input logic [7:0] n, output int cyc, output logic [7:0] res,
                        output logic [4:0] rem, output logic rdy_after, output logic vld_after);
    cyc = -1; res = '0; rem = '0; rdy_after = 1'b0; vld_after = 1'b1;
    @(negedge clk);
    n8 = n; nvld8 = 1'b1; rrdy8 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      nvld8 = 1'b0;
      if (rvld8) begin
        cyc = c;
        res = res8;
`ifdef ISQRT_REMAINDER_EN
        rem = rem8;
`endif
        @(negedge clk);
        rdy_after = nrdy8;
        vld_after = rvld8;
        break;
      end
    end
  endtask

  task automatic drive16(input logic [15:0] n, output int cyc, output logic [15:0] res,
                         output logic [8:0] rem);
    cyc = -1; res = '0; rem = '0;
    @(negedge clk);
    n16 = n; nvld16 = 1'b1; rrdy16 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      nvld16 = 1'b0;
      if (rvld16) begin
        cyc = c;
        res = res16;
`ifdef ISQRT_REMAINDER_EN
        rem = rem16;
`endif
        @(negedge clk);
        break;
      end
    end
  endtask

  task automatic test_reset;
    n8 = '0; nvld8 = 1'b0; rrdy8 = 1'b0;
    n16 = '0; nvld16 = 1'b0; rrdy16 = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (nrdy8 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy8 got %b want 1", nrdy8); end
    n_checks++; if (rvld8 !== 1'b0) begin n_fail++; $display("FAIL reset_vld8 got %b want 0", rvld8); end
    n_checks++; if (res8 !== 8'd0) begin n_fail++; $display("FAIL reset_res8 got %0d want 0", res8); end
    n_checks++; if (nrdy16 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy16 got %b want 1", nrdy16); end
    n_checks++; if (rvld16 !== 1'b0) begin n_fail++; $display("FAIL reset_vld16 got %b want 0", rvld16); end
    n_checks++; if (res16 !== 16'd0) begin n_fail++; $display("FAIL reset_res16 got %0d want 0", res16); end
`ifdef ISQRT_REMAINDER_EN
    n_checks++; if (rem8 !== 5'd0) begin n_fail++; $display("FAIL reset_rem8 got %0d want 0", rem8); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (nrdy8 !== 1'b1) begin n_fail++; $display("FAIL post_reset_rdy8 got %b want 1", nrdy8); end
  endtask

  task automatic test_basic;
    int cyc; logic [7:0] r; logic [4:0] rm; logic ra, va;
    drive8(8'd144, cyc, r, rm, ra, va);
    n_checks++; if (r !== 8'd12) begin n_fail++; $display("FAIL basic_result got %0d want 12", r); end
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", cyc); end
    n_checks++; if (va !== 1'b0) begin n_fail++; $display("FAIL basic_one_vld got %b want 0", va); end
    n_checks++; if (ra !== 1'b1) begin n_fail++; $display("FAIL basic_rdy_back got %b want 1", ra); end
`ifdef ISQRT_REMAINDER_EN
    n_checks++; if (rm !== 5'd0) begin n_fail++; $display("FAIL basic_rem got %0d want 0", rm); end
`endif
  endtask

  task automatic test_boundaries;
    logic [7:0] tbl [5];
    int cyc; logic [7:0] r; logic [4:0] rm; logic ra, va;
    int unsigned e;
    tbl = '{8'd0, 8'd1, 8'd255, 8'd143, 8'd15};
    for (int i = 0; i < 5; i++) begin
      drive8(tbl[i], cyc, r, rm, ra, va);
      e = model_sqrt(tbl[i]);
      n_checks++;
      if (r !== 8'(e)) begin
        n_fail++; $display("FAIL bound_result n=%0d got %0d want %0d", tbl[i], r, e);
      end
      n_checks++;
      if (cyc !== 5) begin n_fail++; $display("FAIL bound_latency n=%0d got %0d want 5", tbl[i], cyc); end
`ifdef ISQRT_REMAINDER_EN
      n_checks++;
      if (rm !== 5'(tbl[i] - e * e)) begin
        n_fail++; $display("FAIL bound_rem n=%0d got %0d want %0d", tbl[i], rm, tbl[i] - e * e);
      end
`endif
    end
  endtask

  task automatic test_backpressure;
    bit seen = 1'b0;
    int cyc; logic [7:0] r; logic [4:0] rm; logic ra, va;
    @(negedge clk);
    n8 = 8'd200; nvld8 = 1'b1; rrdy8 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      nvld8 = 1'b0;
      if (rvld8) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_timeout got no vld want vld"); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (rvld8 !== 1'b1) begin n_fail++; $display("FAIL bp_vld i=%0d got %b want 1", i, rvld8); end
      n_checks++; if (res8 !== 8'd14) begin n_fail++; $display("FAIL bp_result i=%0d got %0d want 14", i, res8); end
      n_checks++; if (nrdy8 !== 1'b0) begin n_fail++; $display("FAIL bp_rdy i=%0d got %b want 0", i, nrdy8); end
      n8 = 8'd9; nvld8 = 1'b1;
      @(negedge clk);
    end
    nvld8 = 1'b0; rrdy8 = 1'b1;
    @(negedge clk);
    n_checks++; if (rvld8 !== 1'b0) begin n_fail++; $display("FAIL bp_release_vld got %b want 0", rvld8); end
    n_checks++; if (nrdy8 !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy got %b want 1", nrdy8); end
    n_checks++; if (res8 !== 8'd14) begin n_fail++; $display("FAIL bp_hold_result got %0d want 14", res8); end
    drive8(8'd9, cyc, r, rm, ra, va);
    n_checks++; if (r !== 8'd3) begin n_fail++; $display("FAIL bp_next_result got %0d want 3", r); end
  endtask

  task automatic test_reset_mid_calc;
    bit leaked = 1'b0;
    int cyc; logic [7:0] r; logic [4:0] rm; logic ra, va;
    @(negedge clk);
    n8 = 8'd255; nvld8 = 1'b1; rrdy8 = 1'b1;
    @(negedge clk);
    nvld8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (rvld8 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_vld got %b want 0", rvld8); end
    n_checks++; if (res8 !== 8'd0) begin n_fail++; $display("FAIL mid_reset_result got %0d want 0", res8); end
    n_checks++; if (nrdy8 !== 1'b1) begin n_fail++; $display("FAIL mid_reset_rdy got %b want 1", nrdy8); end
`ifdef ISQRT_REMAINDER_EN
    n_checks++; if (rem8 !== 5'd0) begin n_fail++; $display("FAIL mid_reset_rem got %0d want 0", rem8); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rvld8) leaked = 1'b1;
    end
    n_checks++; if (leaked) begin n_fail++; $display("FAIL mid_reset_leak got vld want none"); end
    drive8(8'd64, cyc, r, rm, ra, va);
    n_checks++; if (r !== 8'd8) begin n_fail++; $display("FAIL mid_reset_next got %0d want 8", r); end
  endtask

  task automatic test_width16;
    logic [15:0] tbl [3];
    int cyc; logic [15:0] r; logic [8:0] rm;
    int unsigned e;
    tbl = '{16'd65535, 16'd40000, 16'd40401};
    for (int i = 0; i < 3; i++) begin
      drive16(tbl[i], cyc, r, rm);
      e = model_sqrt(tbl[i]);
      n_checks++;
      if (r !== 16'(e)) begin
        n_fail++; $display("FAIL w16_result n=%0d got %0d want %0d", tbl[i], r, e);
      end
      n_checks++;
      if (cyc !== 9) begin n_fail++; $display("FAIL w16_latency n=%0d got %0d want 9", tbl[i], cyc); end
`ifdef ISQRT_REMAINDER_EN
      n_checks++;
      if (rm !== 9'(tbl[i] - e * e)) begin
        n_fail++; $display("FAIL w16_rem n=%0d got %0d want %0d", tbl[i], rm, tbl[i] - e * e);
      end
`endif
    end
  endtask

  // All 256 operands in random order, input valid and result ready held high.
  task automatic test_back_to_back;
    logic [7:0] perm [256];
    logic [7:0] q [$];
    logic [7:0] tmp, op;
    int unsigned j, e;
    int idx = 0, got = 0, last_acc = -1;
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    nvld8 = 1'b0; rrdy8 = 1'b1;
    for (int c = 0; c < 4000 && got < 256; c++) begin
      @(negedge clk);
      if (rvld8) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_spurious got %0d want no result", res8);
        end else begin
          op = q.pop_front();
          e = model_sqrt(op);
          if (res8 !== 8'(e)) begin
            n_fail++; $display("FAIL b2b_result n=%0d got %0d want %0d", op, res8, e);
          end
`ifdef ISQRT_REMAINDER_EN
          n_checks++;
          if (rem8 !== 5'(op - e * e)) begin
            n_fail++; $display("FAIL b2b_rem n=%0d got %0d want %0d", op, rem8, op - e * e);
          end
`endif
        end
        got++;
      end
      if (nrdy8) begin
        if (idx < 256) begin
          if (last_acc >= 0) begin
            n_checks++;
            if (c - last_acc != 6) begin
              n_fail++; $display("FAIL b2b_spacing got %0d want 6", c - last_acc);
            end
          end
          last_acc = c;
          n8 = perm[idx]; nvld8 = 1'b1;
          q.push_back(perm[idx]);
          idx++;
        end else begin
          nvld8 = 1'b0;
        end
      end
    end
    nvld8 = 1'b0;
    n_checks++; if (got != 256) begin n_fail++; $display("FAIL b2b_count got %0d want 256", got); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_reset_mid_calc();
    test_width16();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iterative_sqrt_responder.md
Name: iterative_sqrt_responder

Overview:
- Channel-side responder for the iterative square-root request/response protocol.
- Accepts an unsigned operand on a valid/ready input channel and computes floor(sqrt(n)) with a restoring digit-by-digit loop, one result bit per cycle.
- Returns the result on a valid/ready output channel with full backpressure.
- Drop-in engine behind a go/started request wrapper or any proc-style driver.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2. Odd values are an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- chan_n  input  WIDTH  operand; sampled only on accept handshake
- chan_n_vld  input  1  operand valid
- chan_n_rdy  output  1  operand ready; high only in IDLE
- chan_result  output  WIDTH  root; bits [WIDTH-1:WIDTH/2] always 0
- chan_result_vld  output  1  result valid
- chan_result_rdy  input  1  result ready (consumer)

Behaviour:
- Reset: one clock, clk; reset is asynchronous, active-low on rst_n.
  - Asserting rst_n=0 at any time, including mid-CALC or in DONE, forces state=IDLE, chan_result=0, chan_result_vld=0, internal root/rem/count=0.
  - chan_n_rdy=1 during and after reset. No partial result is ever emitted after reset.
- States: IDLE, CALC, DONE. Let N=WIDTH/2.
- IDLE:
  - chan_n_rdy=1, chan_result_vld=0.
  - On an edge with chan_n_vld=1: latch chan_n into shift reg x, clear root and rem, set count=N-1, go to CALC.
- CALC:
  - chan_n_rdy=0, chan_result_vld=0. chan_n_vld is ignored.
  - Each edge performs one iteration:
    - rem' = (rem<<2) | x[WIDTH-1:WIDTH-2]
    - x <<= 2
    - trial = (root<<2) | 1
    - if rem' >= trial: rem = rem' - trial, root = (root<<1) | 1
    - else: rem = rem', root = root<<1
  - rem is N+2 bits wide and root is N bits; there is no overflow at these widths.
  - When count==0 on an iteration edge, go to DONE and load chan_result={0,root_final}. Otherwise decrement count.
- DONE:
  - chan_result_vld=1 and chan_result is held stable while chan_result_rdy=0, for an unbounded time.
  - On an edge with chan_result_rdy=1, go to IDLE and drop chan_result_vld the next cycle.
  - chan_result keeps its last value until the next DONE load.
- Latency:
  - The accept handshake occurs in cycle 0. chan_result_vld is first high in cycle N+1: cycle 5 for WIDTH=8.
  - Minimum turnaround from result handshake back to chan_n_rdy=1 is one cycle.
  - Throughput is one operation per N+2 cycles.
- No simultaneous accept and return: chan_n_rdy=0 in DONE by construction.
- chan_result_rdy held high permanently is legal. The result then handshakes in its first valid cycle.
- chan_n_rdy and chan_result_vld are decoded from registered state only; there are no combinational input-to-output paths.

Optional Feature:
- Macro: ISQRT_REMAINDER_EN.
- Defined:
  - Adds output port chan_rem, width WIDTH/2+1, holding n - root^2.
  - chan_rem is loaded together with chan_result, held stable in DONE, and reset to 0.
  - It shares chan_result_vld/chan_result_rdy.
- Undefined:
  - The port is absent and only root is retained.
  - Behaviour and latency are otherwise identical.

Test Plan:
- WIDTH=8, n=144, chan_result_rdy=1: result=12 with vld in cycle 5, one vld cycle, chan_n_rdy back high in cycle 6. With ISQRT_REMAINDER_EN, rem=0.
- Boundaries, each with no backpressure:
  - n=0 -> 0
  - n=1 -> 1
  - n=255 -> 15, rem=30
  - n=143 -> 11, rem=22
  - n=15 -> 3, rem=6
- Backpressure: n=200 with chan_result_rdy=0 for 10 cycles -> vld stays 1 and result stays 14 throughout, chan_n_rdy=0 throughout; a new chan_n_vld with n=9 is ignored. After rdy=1 for one edge -> IDLE, then n=9 -> 3.
- Reset mid-CALC: n=255 accepted, rst_n low for one cycle at cycle 2 -> vld=0, result=0, chan_n_rdy=1 immediately. No result is ever returned for 255; the next n=64 -> 8.
- WIDTH=16: n=65535 -> 255, rem=510, vld in cycle 9. n=40000 -> 200, rem=0. n=40401 -> 201.
- Back-to-back with chan_n_vld and chan_result_rdy tied 1 -> accept every 6 cycles (WIDTH=8). A randomized sweep of all 256 operands matches a floor-sqrt model.
